pipeline_hazard_controller: RTL

Drives the controller side of every pipeline register in the five-stage core: the `stall`, `bubble`, `nullify` and `keep_exception` inputs of the F→D, D→E, E→M and M→W registers, plus a PC hold/redirect pair for fetch. It detects load-use hazards, sequences multi-cycle mult/div occupancy of execute, holds the pipe during memory waits and flushes younger instructions when the memory stage raises an exception. It is the single owner of all pipeline-control signals and sits beside the datapath in the core top.

---
 rtl/pipeline_hazard_controller.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Pipeline-control owner for the five-stage core: load-use interlock, mult/div occupancy
// of execute, memory-wait holds and exception flush of every pipeline register and the PC.
module pipeline_hazard_controller #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] dec_rs,
  input  logic [4:0] dec_rt,
  input  logic       dec_use_rs,
  input  logic       dec_use_rt,
  input  logic       ex_is_load,
  input  logic [4:0] ex_dest_reg,
  input  logic       ex_muldiv_start,
  input  logic       ex_is_div,
  input  logic       mem_wait,
  input  logic       mem_exception,
  output logic       pc_stall,
  output logic       pc_redirect,
  output logic [3:0] stall,
  output logic [3:0] bubble,
  output logic [3:0] nullify,
  output logic [3:0] keep_exception,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StMuldiv = 2'd1,
    StFlush  = 2'd2
  } state_e;

  localparam logic [5:0] MulLoad = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DivLoad = 6'(DIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       muldiv_entry;
  logic       muldiv_busy;
  logic       load_use;

  assign muldiv_entry = (state_q == StRun) && ex_muldiv_start;
  assign muldiv_busy  = (state_q == StMuldiv) && (cnt_q != 6'd0);
  assign load_use     = ex_is_load && (ex_dest_reg != 5'd0) &&
                        ((dec_use_rs && (dec_rs == ex_dest_reg)) ||
                         (dec_use_rt && (dec_rt == ex_dest_reg)));
  assign state        = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_stall       = 1'b0;
    pc_redirect    = 1'b0;
    stall          = 4'b0000;
    bubble         = 4'b0000;
    nullify        = 4'b0000;
    keep_exception = 4'b0000;
    state_d        = state_q;
    cnt_d          = cnt_q;

    if (reset) begin
      nullify = 4'b1111;
    end else if (mem_exception && (state_q != StFlush)) begin
      // Kill everything younger; M->W still latches the cop0 exception info.
      nullify        = 4'b1111;
      keep_exception = 4'b1000;
      pc_redirect    = 1'b1;
      state_d        = StFlush;
      cnt_d          = 6'd0;
    end else begin
      if (mem_wait) begin
        pc_stall = 1'b1;
        stall    = 4'b0111;
        bubble   = 4'b1000;
      end else if (muldiv_entry || muldiv_busy) begin
        pc_stall = 1'b1;
        stall    = 4'b0011;
        bubble   = 4'b0100;
      end else if (load_use) begin
        pc_stall = 1'b1;
        stall    = 4'b0001;
        bubble   = 4'b0010;
      end

      case (state_q)
        StRun: begin
          if (ex_muldiv_start) begin
            cnt_d   = ex_is_div ? DivLoad : MulLoad;
            state_d = StMuldiv;
          end
        end
        StMuldiv: begin
          // Holding in MULDIV at cnt=0 during mem_wait stops a stalled op re-triggering.
          if (cnt_q != 6'd0) begin
            cnt_d = cnt_q - 6'd1;
          end else if (!mem_wait) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

endmodule
